// File: rtl/serial_link_pkg.sv
// Shared types and helpers for the serial-link data-link TX/RX stages.
package serial_link_pkg;

  localparam int unsigned DefaultNumLanes = 8;
  localparam int unsigned DefaultBeatWidth = 2 * DefaultNumLanes;

  // One PHY beat: two bits per lane.
  typedef logic [DefaultBeatWidth-1:0] beat_t;

  // TX framing FSM states.
  typedef enum logic [0:0] {
    TxIdle = 1'b0,
    TxSend = 1'b1
  } tx_state_e;

  // Number of beats needed to carry one payload; never less than one.
  function automatic int unsigned num_beats(input int unsigned payload_width,
                                            input int unsigned num_lanes);
    int unsigned bw;
    int unsigned nb;
    bw = 32'd2 * num_lanes;
    nb = (payload_width + bw - 32'd1) / bw;
    if (nb < 32'd1) begin
      nb = 32'd1;
    end else begin
      nb = nb;
    end
    return nb;
  endfunction

endpackage

// File: rtl/serial_link_credit_counter.sv
// Saturating up/down credit counter with a registered overflow pulse.
module serial_link_credit_counter
  import serial_link_pkg::*;
#(
  parameter  int unsigned NumCredits = 8,
  localparam int unsigned CntW       = $clog2(NumCredits + 1)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            consume_i,
  input  logic            return_i,
  output logic [CntW-1:0] credits_o,
  output logic            overflow_o
);

  localparam logic [CntW-1:0] MaxCount = CntW'(NumCredits);

  logic [CntW-1:0] count_r;
  logic [CntW-1:0] count_n_s;
  logic            overflow_r;
  logic            overflow_n_s;

  // Next count: a coincident consume and return cancel out; a lone return at max saturates.
  always_comb begin
    count_n_s    = count_r;
    overflow_n_s = 1'b0;
    case ({consume_i, return_i})
      2'b10: begin
        if (count_r != {CntW{1'b0}}) begin
          count_n_s = count_r - CntW'(1);
        end else begin
          count_n_s = count_r;
        end
      end
      2'b01: begin
        if (count_r == MaxCount) begin
          overflow_n_s = 1'b1;
        end else begin
          count_n_s = count_r + CntW'(1);
        end
      end
      default: begin
        count_n_s = count_r;
      end
    endcase
  end

  // Count and overflow registers; reset reloads the full credit allotment.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_r    <= MaxCount;
      overflow_r <= 1'b0;
    end else begin
      count_r    <= count_n_s;
      overflow_r <= overflow_n_s;
    end
  end

  assign credits_o  = count_r;
  assign overflow_o = overflow_r;

endmodule

// File: rtl/serial_link_data_link_tx.sv
// Data-link TX: slices credit-gated payloads into PHY beats.
module serial_link_data_link_tx
  import serial_link_pkg::*;
#(
  parameter  int unsigned NumLanes     = 8,
  parameter  int unsigned PayloadWidth = 40,
  parameter  int unsigned NumCredits   = 8,
  localparam int unsigned BW           = 2 * NumLanes,
  localparam int unsigned CreditW      = $clog2(NumCredits + 1)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [PayloadWidth-1:0] data_i,
  input  logic                    data_valid_i,
  output logic                    data_ready_o,
  output logic [BW-1:0]           phy_data_o,
  output logic                    phy_valid_o,
  input  logic                    phy_ready_i,
  input  logic                    credit_return_i,
  output logic [CreditW-1:0]      credits_o,
  output logic                    credit_overflow_o
);

  localparam int unsigned NumBeats = num_beats(PayloadWidth, NumLanes);
  localparam int unsigned PadW     = NumBeats * BW;
  localparam int unsigned BeatIdxW = (NumBeats > 1) ? $clog2(NumBeats) : 1;
  localparam logic [BeatIdxW-1:0] LastBeat = BeatIdxW'(NumBeats - 1);

  tx_state_e             state_r;
  tx_state_e             state_n_s;
  logic [BeatIdxW-1:0]   beat_r;
  logic [BeatIdxW-1:0]   beat_n_s;
  logic [PadW-1:0]       payload_r;
  logic                  load_s;
  logic                  ready_s;
  logic                  valid_s;
  logic                  credits_nz_s;
  logic [CreditW-1:0]    credits_s;
  logic [BW-1:0]         beats_s [NumBeats];

  // Payload register is zero-padded to whole beats, so the tail of the last beat reads zero.
  for (genvar g = 0; g < NumBeats; g++) begin : g_slice
    assign beats_s[g] = payload_r[g*BW +: BW];
  end

  assign credits_nz_s = (credits_s != {CreditW{1'b0}});

  // Framing FSM: a new payload may only be taken when idle or on the last-beat handshake.
  always_comb begin
    state_n_s = state_r;
    beat_n_s  = beat_r;
    load_s    = 1'b0;
    ready_s   = 1'b0;
    valid_s   = 1'b0;
    case (state_r)
      TxIdle: begin
        ready_s = credits_nz_s;
        if (data_valid_i && credits_nz_s) begin
          load_s    = 1'b1;
          beat_n_s  = {BeatIdxW{1'b0}};
          state_n_s = TxSend;
        end else begin
          state_n_s = TxIdle;
        end
      end
      TxSend: begin
        valid_s = 1'b1;
        if (phy_ready_i) begin
          if (beat_r != LastBeat) begin
            beat_n_s = beat_r + BeatIdxW'(1);
          end else begin
            ready_s = credits_nz_s;
            if (data_valid_i && credits_nz_s) begin
              load_s    = 1'b1;
              beat_n_s  = {BeatIdxW{1'b0}};
              state_n_s = TxSend;
            end else begin
              state_n_s = TxIdle;
            end
          end
        end else begin
          beat_n_s = beat_r;
        end
      end
      default: begin
        state_n_s = TxIdle;
      end
    endcase
  end

  // State, beat index and payload registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r   <= TxIdle;
      beat_r    <= {BeatIdxW{1'b0}};
      payload_r <= {PadW{1'b0}};
    end else begin
      state_r <= state_n_s;
      beat_r  <= beat_n_s;
      if (load_s) begin
        payload_r <= PadW'(data_i);
      end else begin
        payload_r <= payload_r;
      end
    end
  end

  serial_link_credit_counter #(
    .NumCredits(NumCredits)
  ) u_credits (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .consume_i (load_s),
    .return_i  (credit_return_i),
    .credits_o (credits_s),
    .overflow_o(credit_overflow_o)
  );

  assign data_ready_o = ready_s;
  assign phy_valid_o  = valid_s;
  assign phy_data_o   = beats_s[beat_r];
  assign credits_o    = credits_s;

endmodule

// File: tb/tb_serial_link_data_link_tx.sv
// Self-checking bench for serial_link_data_link_tx: queue-based model plus directed literal checks.
module tb_serial_link_data_link_tx;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic        rst_ni;
  // main DUT (8 credits)
  logic [39:0] data;
  logic        data_valid;
  logic        data_ready;
  logic [15:0] phy_data;
  logic        phy_valid;
  logic        phy_ready;
  logic        ret;
  logic [3:0]  credits;
  logic        ovf;
  // small DUT (2 credits) for exhaustion
  logic [39:0] c2_data;
  logic        c2_valid;
  logic        c2_ready;
  logic [15:0] c2_phy_data;
  logic        c2_phy_valid;
  logic        c2_phy_ready;
  logic        c2_ret;
  logic [1:0]  c2_credits;
  logic        c2_ovf;

  int total = 0;
  int bad   = 0;

  serial_link_data_link_tx #(.NumLanes(8), .PayloadWidth(40), .NumCredits(8)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .data_i(data), .data_valid_i(data_valid),
    .data_ready_o(data_ready), .phy_data_o(phy_data), .phy_valid_o(phy_valid),
    .phy_ready_i(phy_ready), .credit_return_i(ret), .credits_o(credits),
    .credit_overflow_o(ovf)
  );

  serial_link_data_link_tx #(.NumLanes(8), .PayloadWidth(40), .NumCredits(2)) dut_c2 (
    .clk_i(clk_i), .rst_ni(rst_ni), .data_i(c2_data), .data_valid_i(c2_valid),
    .data_ready_o(c2_ready), .phy_data_o(c2_phy_data), .phy_valid_o(c2_phy_valid),
    .phy_ready_i(c2_phy_ready), .credit_return_i(c2_ret), .credits_o(c2_credits),
    .credit_overflow_o(c2_ovf)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk_i);
  endtask

  // Model: queue of beats still owed for the current packet plus an integer credit count.
  logic [15:0] mq[$];
  int          m_cred = 8;
  logic        m_ovf  = 1'b0;

  // Compare DUT to model at each falling edge, then advance the model with the same inputs
  // the DUT will see at the next rising edge.
  always @(negedge clk_i) begin
    logic [47:0] padded;
    logic        acc;
    logic        hs;
    logic        exp_ready;
    if (!rst_ni) begin
      mq.delete();
      m_cred = 8;
      m_ovf  = 1'b0;
    end
    exp_ready = (m_cred != 0) && ((mq.size() == 0) || ((mq.size() == 1) && phy_ready));
    chk("m_valid", 64'(phy_valid), 64'(mq.size() != 0));
    if (mq.size() != 0) chk("m_data", 64'(phy_data), 64'(mq[0]));
    chk("m_ready", 64'(data_ready), 64'(exp_ready));
    chk("m_credits", 64'(credits), 64'(m_cred));
    chk("m_overflow", 64'(ovf), 64'(m_ovf));
    if (rst_ni) begin
      acc = data_valid && exp_ready;
      hs  = (mq.size() != 0) && phy_ready;
      if (hs) void'(mq.pop_front());
      if (acc) begin
        padded = {8'h00, data};
        for (int k = 0; k < 3; k++) mq.push_back(padded[k*16 +: 16]);
      end
      m_ovf = 1'b0;
      if (acc && !ret) m_cred = m_cred - 1;
      else if (ret && !acc) begin
        if (m_cred == 8) m_ovf = 1'b1;
        else m_cred = m_cred + 1;
      end
    end
  end

  // Offer n packets back to back on the main DUT; reports accept count and valid-beat span.
  task automatic send_b2b(input int n, input logic [39:0] base,
                          output int accepted, output int vcount,
                          output int first_v, output int last_v);
    logic acc;
    accepted = 0; vcount = 0; first_v = -1; last_v = -1;
    data = base;
    data_valid = 1'b1;
    for (int c = 0; c < 3 * n + 6; c++) begin
      at_neg();
      acc = data_valid & data_ready;
      if (phy_valid) begin
        vcount++;
        if (first_v < 0) first_v = c;
        last_v = c;
      end
      tick();
      if (acc) begin
        accepted++;
        if (accepted < n) data = data ^ 40'hFF_00FF_0F0F;
        else data_valid = 1'b0;
      end
    end
  endtask

  initial begin
    int   nacc, vcnt, fv, lv, cnt_v, cnt_b1;
    logic acc;
    rst_ni = 1'b0;
    data = 40'h0; data_valid = 1'b0; phy_ready = 1'b1; ret = 1'b0;
    c2_data = 40'h0; c2_valid = 1'b0; c2_phy_ready = 1'b1; c2_ret = 1'b0;

    // Reset values
    at_neg();
    chk("rst_valid", 64'(phy_valid), 64'd0);
    chk("rst_data", 64'(phy_data), 64'd0);
    chk("rst_credits", 64'(credits), 64'd8);
    chk("rst_ovf", 64'(ovf), 64'd0);
    chk("rst_ready", 64'(data_ready), 64'd1);
    chk("rst_c2_credits", 64'(c2_credits), 64'd2);
    tick();
    rst_ni = 1'b1;

    // Single packet, PHY always ready
    data = 40'hAB_CDEF_1234; data_valid = 1'b1;
    at_neg(); chk("s1_ready", 64'(data_ready), 64'd1);
    tick(); data_valid = 1'b0;
    at_neg();
    chk("s1_b0", 64'(phy_data), 64'h1234);
    chk("s1_v0", 64'(phy_valid), 64'd1);
    chk("s1_cred", 64'(credits), 64'd7);
    tick(); at_neg();
    chk("s1_b1", 64'(phy_data), 64'hCDEF);
    chk("s1_rdy_mid", 64'(data_ready), 64'd0);
    tick(); at_neg();
    chk("s1_b2", 64'(phy_data), 64'h00AB);
    chk("s1_rdy_last", 64'(data_ready), 64'd1);
    tick(); at_neg();
    chk("s1_drop", 64'(phy_valid), 64'd0);
    tick();

    // PHY backpressure: ready every 4th cycle
    data = 40'h11_2233_4455; data_valid = 1'b1; phy_ready = 1'b0;
    cnt_v = 0; cnt_b1 = 0;
    for (int c = 0; c < 16; c++) begin
      at_neg();
      acc = data_valid & data_ready;
      if (phy_valid) cnt_v++;
      if (phy_valid && (phy_data == 16'h2233)) cnt_b1++;
      tick();
      if (acc) data_valid = 1'b0;
      phy_ready = ((c + 1) % 4 == 3);
    end
    chk("s2_valid_cycles", 64'(cnt_v), 64'd11);
    chk("s2_beat1_hold", 64'(cnt_b1), 64'd4);
    phy_ready = 1'b1;

    // Return two credits to get back to 8
    ret = 1'b1; tick(); tick(); ret = 1'b0;
    at_neg(); chk("ret_cred8", 64'(credits), 64'd8);
    tick();

    // Back-to-back two packets
    send_b2b(2, 40'h01_0203_0405, nacc, vcnt, fv, lv);
    at_neg();
    chk("s3_accepted", 64'(nacc), 64'd2);
    chk("s3_beats", 64'(vcnt), 64'd6);
    chk("s3_no_bubble", 64'(lv - fv + 1), 64'd6);
    chk("s3_cred", 64'(credits), 64'd6);
    tick();

    // Return at full credits -> saturate with one overflow pulse
    ret = 1'b1; tick(); tick();
    at_neg();
    chk("s4_cred8", 64'(credits), 64'd8);
    chk("s4_no_ovf", 64'(ovf), 64'd0);
    tick(); ret = 1'b0;
    at_neg();
    chk("s4_sat", 64'(credits), 64'd8);
    chk("s4_ovf", 64'(ovf), 64'd1);
    tick(); at_neg();
    chk("s4_ovf_once", 64'(ovf), 64'd0);
    tick();

    // Consume down to 5, then accept coincident with a return
    send_b2b(3, 40'h77_8899_AABB, nacc, vcnt, fv, lv);
    data = 40'h12_3456_789A; data_valid = 1'b1; ret = 1'b1;
    at_neg();
    chk("s4_cred5", 64'(credits), 64'd5);
    chk("s4_rdy5", 64'(data_ready), 64'd1);
    tick(); data_valid = 1'b0; ret = 1'b0;
    at_neg();
    chk("s4_coinc_cred", 64'(credits), 64'd5);
    chk("s4_coinc_ovf", 64'(ovf), 64'd0);
    chk("s4_coinc_b0", 64'(phy_data), 64'h789A);
    tick(); tick(); tick();

    // Reset during beat 1
    data = 40'hFE_DCBA_9876; data_valid = 1'b1;
    at_neg(); tick(); data_valid = 1'b0;
    tick(); at_neg();
    chk("s5_beat1", 64'(phy_data), 64'hDCBA);
    #2 rst_ni = 1'b0;
    tick(); at_neg();
    chk("s5_rst_valid", 64'(phy_valid), 64'd0);
    chk("s5_rst_cred", 64'(credits), 64'd8);
    tick(); rst_ni = 1'b1;
    data = 40'h55_6677_8899; data_valid = 1'b1;
    at_neg(); chk("s5_ready", 64'(data_ready), 64'd1);
    tick(); data_valid = 1'b0;
    at_neg();
    chk("s5_new_b0", 64'(phy_data), 64'h8899);
    chk("s5_new_cred", 64'(credits), 64'd7);
    tick(); tick(); tick();

    // Credit exhaustion on the 2-credit instance
    c2_data = 40'hA1_A2A3_A4A5; c2_valid = 1'b1; nacc = 0;
    for (int c = 0; c < 10; c++) begin
      at_neg();
      acc = c2_valid & c2_ready;
      tick();
      if (acc) begin
        nacc++;
        c2_data = (nacc == 1) ? 40'hB1_B2B3_B4B5 : 40'hC1_C2C3_C4C5;
      end
    end
    at_neg();
    chk("c2_accepted", 64'(nacc), 64'd2);
    chk("c2_cred0", 64'(c2_credits), 64'd0);
    chk("c2_blocked", 64'(c2_ready), 64'd0);
    chk("c2_idle", 64'(c2_phy_valid), 64'd0);
    tick(); c2_ret = 1'b1;
    tick(); c2_ret = 1'b0;
    at_neg();
    chk("c2_cred1", 64'(c2_credits), 64'd1);
    chk("c2_ready1", 64'(c2_ready), 64'd1);
    tick(); c2_valid = 1'b0;
    at_neg();
    chk("c2_cred_back0", 64'(c2_credits), 64'd0);
    chk("c2_b0", 64'(c2_phy_data), 64'hC4C5);
    chk("c2_v0", 64'(c2_phy_valid), 64'd1);
    tick(); at_neg(); chk("c2_b1", 64'(c2_phy_data), 64'hC2C3);
    tick(); at_neg(); chk("c2_b2", 64'(c2_phy_data), 64'h00C1);
    tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
